// File: rtl/imem_uart_loader.sv
// imem_uart_loader: packs a UART byte stream into 32-bit big-endian words
// (first byte = MSB) and writes them to the instruction RAM write port.
// A load ends at HALT_WORD (which is itself written) or when the RAM is full.
// Optional build macro LOADER_TIMEOUT_EN: discard a partial word after
// TIMEOUT_CYCLES idle cycles. When undefined, o_timeout is tied low.

module imem_uart_loader #(
   parameter int                  NB_DATA        = 32,
   parameter int                  NB_ADDR        = 8,
   parameter logic [NB_DATA-1:0]  HALT_WORD      = 32'hFFFF_FFFF,
   parameter int                  TIMEOUT_CYCLES = 100000
) (
   input  logic                 clk,
   input  logic                 i_rst_n,
   input  logic                 i_start,
   input  logic [7:0]           i_rx_data,
   input  logic                 i_rx_valid,
   output logic                 o_we,
   output logic [NB_ADDR-1:0]   o_addr,
   output logic [NB_DATA-1:0]   o_data,
   output logic                 o_busy,
   output logic                 o_done,
   output logic                 o_overflow,
   output logic                 o_timeout,
   output logic [NB_ADDR-2:0]   o_word_count
);

   // Capacity in words; o_word_count is one bit wider than a word index so
   // a completely full RAM can be reported.
   localparam int                 CAPACITY   = 2 ** (NB_ADDR - 2);
   localparam logic [NB_ADDR-2:0] CAP_WORDS  = (NB_ADDR - 1)'(CAPACITY);
   localparam logic [NB_ADDR-2:0] LAST_WORD  = (NB_ADDR - 1)'(CAPACITY - 1);
   localparam logic [NB_ADDR-1:0] WORD_BYTES = (NB_ADDR)'(4);

   // Reject configurations the packing and addressing logic cannot handle.
   if (NB_DATA != 32) begin : g_bad_width
      $error("imem_uart_loader: NB_DATA must be 32");
   end
   if (NB_ADDR < 3) begin : g_bad_addr
      $error("imem_uart_loader: NB_ADDR must be at least 3");
   end
   if (TIMEOUT_CYCLES < 1) begin : g_bad_timeout
      $error("imem_uart_loader: TIMEOUT_CYCLES must be at least 1");
   end

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_RECV  = 2'd1,
      S_WRITE = 2'd2,
      S_DONE  = 2'd3
   } state_t;

   state_t               state_q,    state_d;
   logic [NB_DATA-1:0]   word_q,     word_d;      // byte shift register
   logic [NB_DATA-1:0]   data_q,     data_d;      // last completed word
   logic [1:0]           byte_cnt_q, byte_cnt_d;
   logic [NB_ADDR-1:0]   base_q,     base_d;
   logic [NB_ADDR-2:0]   wc_q,       wc_d;
   logic                 ovf_q,      ovf_d;
   logic [NB_DATA-1:0]   word_shift;

`ifdef LOADER_TIMEOUT_EN
   localparam int            TMO_W    = $clog2(TIMEOUT_CYCLES + 1);
   localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT_CYCLES - 1);

   logic [TMO_W-1:0]     tmo_cnt_q, tmo_cnt_d;
   logic                 tmo_q,     tmo_d;
`endif

   assign word_shift = {word_q[NB_DATA-9:0], i_rx_data};

   // Next-state and datapath update for every register.
   always_comb begin
      // NOTE: every target gets a default first, so no path through the
      // case statement can leave a signal unassigned and infer a latch.
      state_d    = state_q;
      word_d     = word_q;
      data_d     = data_q;
      byte_cnt_d = byte_cnt_q;
      base_d     = base_q;
      wc_d       = wc_q;
      ovf_d      = ovf_q;
`ifdef LOADER_TIMEOUT_EN
      tmo_cnt_d  = '0;
      tmo_d      = 1'b0;
`endif

      unique case (state_q)
         S_IDLE, S_DONE: begin
            if (i_start) begin
               state_d    = S_RECV;
               word_d     = '0;
               byte_cnt_d = '0;
               base_d     = '0;
               wc_d       = '0;
               ovf_d      = 1'b0;
            end else if (state_q == S_DONE && i_rx_valid && wc_q == CAP_WORDS) begin
               // Data kept coming after the RAM filled up.
               ovf_d = 1'b1;
            end
         end

         S_RECV: begin
            if (i_rx_valid) begin
               word_d     = word_shift;
               byte_cnt_d = byte_cnt_q + 2'd1;
               if (byte_cnt_q == 2'd3) begin
                  data_d  = word_shift;
                  state_d = S_WRITE;
               end
`ifdef LOADER_TIMEOUT_EN
            end else if (byte_cnt_q != 2'd0) begin
               if (tmo_cnt_q == TMO_LAST) begin
                  // Stalled mid-word: drop the partial word, keep the slot.
                  word_d     = '0;
                  byte_cnt_d = '0;
                  tmo_d      = 1'b1;
               end else begin
                  tmo_cnt_d = tmo_cnt_q + 1'b1;
               end
`endif
            end
         end

         S_WRITE: begin
            base_d = base_q + WORD_BYTES;
            wc_d   = wc_q + 1'b1;
            if (data_q == HALT_WORD || wc_q == LAST_WORD) begin
               state_d = S_DONE;
               if (i_rx_valid && wc_q == LAST_WORD) begin
                  ovf_d = 1'b1;
               end
            end else begin
               state_d = S_RECV;
               // A byte arriving during the write starts the next word.
               if (i_rx_valid) begin
                  word_d     = word_shift;
                  byte_cnt_d = byte_cnt_q + 2'd1;
               end
            end
         end

         default: state_d = S_IDLE;
      endcase
   end

   // State and datapath registers with asynchronous reset.
   always_ff @(posedge clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         state_q    <= S_IDLE;
         word_q     <= '0;
         data_q     <= '0;
         byte_cnt_q <= '0;
         base_q     <= '0;
         wc_q       <= '0;
         ovf_q      <= 1'b0;
      end else begin
         // NOTE: non-blocking assignments so every flop samples the values
         // computed from the previous cycle, independent of statement order.
         state_q    <= state_d;
         word_q     <= word_d;
         data_q     <= data_d;
         byte_cnt_q <= byte_cnt_d;
         base_q     <= base_d;
         wc_q       <= wc_d;
         ovf_q      <= ovf_d;
      end
   end

`ifdef LOADER_TIMEOUT_EN
   // Inter-byte idle counter and the one-cycle discard pulse.
   always_ff @(posedge clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         tmo_cnt_q <= '0;
         tmo_q     <= 1'b0;
      end else begin
         tmo_cnt_q <= tmo_cnt_d;
         tmo_q     <= tmo_d;
      end
   end

   assign o_timeout = tmo_q;
`else
   assign o_timeout = 1'b0;
`endif

   // The RAM stores the word just below o_addr, so a write presents base+4;
   // otherwise o_addr shows the next free slot.
   assign o_we         = (state_q == S_WRITE);
   assign o_addr       = o_we ? (base_q + WORD_BYTES) : base_q;
   assign o_data       = data_q;
   assign o_busy       = (state_q == S_RECV) || (state_q == S_WRITE);
   assign o_done       = (state_q == S_DONE);
   assign o_overflow   = ovf_q;
   assign o_word_count = wc_q;

endmodule
